// File: rtl/aidc_lite_blk_packer_pkg.sv
// rtl/aidc_lite_blk_packer_pkg.sv - shared constants, state type and word check for the block packer
package aidc_lite_pkg;

   localparam int BLK_WORDS  = 32;
   localparam int PACK_WORDS = 16;
   localparam int DATA_W     = 32;
   localparam int HALF_W     = DATA_W / 2;

   typedef enum logic {
      S_FILL  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   // True when the word is fully described by its low half (upper half is sign fill).
   function automatic logic is_small(input logic [DATA_W-1:0] word);
      return word[DATA_W-1:HALF_W] == {HALF_W{word[HALF_W-1]}};
   endfunction

endpackage

// File: rtl/aidc_lite_blk_packer_if.sv
// rtl/aidc_lite_blk_packer_if.sv - output word stream from the packer to the write-back path
interface aidc_lite_blk_packer_if;
   import aidc_lite_pkg::*;

   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic              out_last_o;
   logic              comp_ok_o;
   logic [5:0]        out_beats_o;

   modport master (
      output out_valid_o,
      input  out_ready_i,
      output out_data_o,
      output out_last_o,
      output comp_ok_o,
      output out_beats_o
   );

   modport slave (
      input  out_valid_o,
      output out_ready_i,
      input  out_data_o,
      input  out_last_o,
      input  comp_ok_o,
      input  out_beats_o
   );

endinterface

// File: rtl/aidc_lite_blk_buf.sv
// rtl/aidc_lite_blk_buf.sv - 32-word block store, one write port and an even/odd read pair
module aidc_lite_blk_buf
   import aidc_lite_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [4:0]        wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_idx_a,
   input  logic [4:0]        rd_idx_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [DATA_W-1:0] mem [BLK_WORDS];

   // Contents are only read after a full block has been written, so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data_a = mem[rd_idx_a];
   assign rd_data_b = mem[rd_idx_b];

endmodule

// File: rtl/aidc_lite_blk_packer.sv
// rtl/aidc_lite_blk_packer.sv - captures a 128B block, tests it for 16-bit packability, streams packed or raw words
module aidc_lite_blk_packer
   import aidc_lite_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  buf_wren_i,
   input  logic [DATA_W-1:0]     buf_wdata_i,
   input  logic                  blk_ready_i,
   input  logic                  clear_i,
   output logic                  err_o,
   aidc_lite_blk_packer_if.master out_if
);

   state_t      state_q, state_d;
   logic [5:0]  wr_cnt_q, wr_cnt_d;
   logic [5:0]  rd_cnt_q, rd_cnt_d;
   logic        ok_acc_q, ok_acc_d;
   logic        comp_ok_q, comp_ok_d;
   logic        err_q, err_d;

   logic              buf_we;
   logic [5:0]        fill_cnt;
   logic              fill_ok;
   logic              draining;
   logic              is_last;
   logic [5:0]        beats;
   logic [4:0]        pair_idx;
   logic [DATA_W-1:0] rd_a, rd_b;

   assign draining = (state_q == S_DRAIN);
   assign beats    = comp_ok_q ? 6'(PACK_WORDS) : 6'(BLK_WORDS);
   assign is_last  = (rd_cnt_q == beats - 6'd1);

   // Both modes read an even/odd pair: packed beat k uses words 2k/2k+1, raw beat k picks from pair k/2.
   assign pair_idx = comp_ok_q ? {rd_cnt_q[3:0], 1'b0} : {rd_cnt_q[4:1], 1'b0};

   aidc_lite_blk_buf u_buf (
      .clk       (clk),
      .wr_en     (buf_we),
      .wr_idx    (wr_cnt_q[4:0]),
      .wr_data   (buf_wdata_i),
      .rd_idx_a  (pair_idx),
      .rd_idx_b  (pair_idx | 5'd1),
      .rd_data_a (rd_a),
      .rd_data_b (rd_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FILL;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         ok_acc_q  <= 1'b1;
         comp_ok_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         ok_acc_q  <= ok_acc_d;
         comp_ok_q <= comp_ok_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      ok_acc_d  = ok_acc_q;
      comp_ok_d = comp_ok_q;
      err_d     = err_q;
      buf_we    = 1'b0;
      fill_cnt  = wr_cnt_q;
      fill_ok   = ok_acc_q;

      case (state_q)
         S_FILL: begin
            if (buf_wren_i) begin
               if (wr_cnt_q == 6'(BLK_WORDS)) begin
                  err_d = 1'b1;
               end else begin
                  buf_we = 1'b1;
               end
            end
            // blk_ready sees the count and flag including a same-cycle write.
            fill_cnt = wr_cnt_q + {5'd0, buf_we};
            fill_ok  = ok_acc_q & (~buf_we | is_small(buf_wdata_i));
            wr_cnt_d = fill_cnt;
            ok_acc_d = fill_ok;
            if (blk_ready_i) begin
               if (fill_cnt == 6'(BLK_WORDS)) begin
                  comp_ok_d = fill_ok;
                  rd_cnt_d  = '0;
                  state_d   = S_DRAIN;
               end else begin
                  err_d    = 1'b1;
                  wr_cnt_d = '0;
                  ok_acc_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (buf_wren_i || blk_ready_i) begin
               err_d = 1'b1;
            end
            if (out_if.out_ready_i) begin
               if (is_last) begin
                  state_d  = S_FILL;
                  wr_cnt_d = '0;
                  rd_cnt_d = '0;
                  ok_acc_d = 1'b1;
               end else begin
                  rd_cnt_d = rd_cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase

      if (clear_i) begin
         state_d  = S_FILL;
         wr_cnt_d = '0;
         rd_cnt_d = '0;
         ok_acc_d = 1'b1;
         err_d    = 1'b0;
         buf_we   = 1'b0;
      end
   end

   // Outputs derive from registered state, so an asynchronous reset clears them at once.
   always_comb begin
      out_if.out_data_o = '0;
      if (draining) begin
         if (comp_ok_q) begin
            out_if.out_data_o = {rd_b[HALF_W-1:0], rd_a[HALF_W-1:0]};
         end else begin
            out_if.out_data_o = rd_cnt_q[0] ? rd_b : rd_a;
         end
      end
   end

   assign out_if.out_valid_o = draining;
   assign out_if.out_last_o  = draining & is_last;
   assign out_if.comp_ok_o   = draining & comp_ok_q;
   assign out_if.out_beats_o = draining ? beats : 6'd0;
   assign err_o              = err_q;

endmodule

// File: tb/tb_aidc_lite_blk_packer.sv
// tb/tb_aidc_lite_blk_packer.sv - directed block scenarios checked against a queue-based beat model
module tb_aidc_lite_blk_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        buf_wren_i = 1'b0;
   logic [31:0] buf_wdata_i = '0;
   logic        blk_ready_i = 1'b0;
   logic        clear_i = 1'b0;
   logic        err_o;

   aidc_lite_blk_packer_if out_if();

   aidc_lite_blk_packer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .buf_wren_i  (buf_wren_i),
      .buf_wdata_i (buf_wdata_i),
      .blk_ready_i (blk_ready_i),
      .clear_i     (clear_i),
      .err_o       (err_o),
      .out_if      (out_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        comp;
      logic [5:0]  beats;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] cap_data[$];
   logic        cap_last[$];
   logic        cap_comp[$];
   int          n_checks = 0;
   int          n_pass = 0;
   bit          run = 1'b0;
   logic [31:0] w [32];
   bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   function automatic bit fits_16(input logic [31:0] v);
      return ($signed(v) >= -32768) && ($signed(v) <= 32767);
   endfunction

   // Expected beat list for a complete 32-word block.
   task automatic expect_block(input logic [31:0] blk [32]);
      bit    comp = 1'b1;
      beat_t b;
      int    n;
      for (int i = 0; i < 32; i++) comp = comp & fits_16(blk[i]);
      n = comp ? 16 : 32;
      for (int k = 0; k < n; k++) begin
         b.data  = comp ? {blk[2*k+1][15:0], blk[2*k][15:0]} : blk[k];
         b.last  = (k == n - 1);
         b.comp  = comp;
         b.beats = 6'(n);
         exp_q.push_back(b);
      end
   endtask

   task automatic write_block(input logic [31:0] blk [32], input int n, input bit rdy_same,
                              input bit accept);
      cap_data.delete();
      cap_last.delete();
      cap_comp.delete();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         buf_wren_i  = 1'b1;
         buf_wdata_i = blk[i];
         blk_ready_i = rdy_same && (i == n - 1);
      end
      @(posedge clk); #1;
      buf_wren_i  = 1'b0;
      blk_ready_i = !rdy_same;
      if (!rdy_same) begin
         @(posedge clk); #1;
         blk_ready_i = 1'b0;
      end
      chk("first_valid_latency", out_if.out_valid_o, accept);
   endtask

   task automatic wait_drain(input bit bp);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 400) begin
         @(posedge clk); #1;
         out_if.out_ready_i = bp ? pat[cyc % 4] : 1'b1;
         cyc++;
      end
      out_if.out_ready_i = 1'b1;
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (run && rst_n && !clear_i) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", out_if.out_valid_o, 1'b0);
         end else if (out_if.out_valid_o) begin
            e = exp_q[0];
            chk("beat_data", out_if.out_data_o, e.data);
            chk("beat_last", out_if.out_last_o, e.last);
            chk("beat_comp_ok", out_if.comp_ok_o, e.comp);
            chk("beat_count", out_if.out_beats_o, e.beats);
            if (out_if.out_ready_i) begin
               cap_data.push_back(out_if.out_data_o);
               cap_last.push_back(out_if.out_last_o);
               cap_comp.push_back(out_if.comp_ok_o);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int cyc;
      out_if.out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_if.out_valid_o, 1'b0);
      chk("rst_data", out_if.out_data_o, 32'h0);
      chk("rst_beats", out_if.out_beats_o, 6'd0);
      chk("rst_comp_ok", out_if.comp_ok_o, 1'b0);
      chk("rst_last", out_if.out_last_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      rst_n = 1'b1;
      run   = 1'b1;

      // packed block of 0..31
      for (int i = 0; i < 32; i++) w[i] = 32'(i);
      expect_block(w);
      write_block(w, 32, 1'b0, 1'b1);
      wait_drain(1'b0);
      chk("t1_count", cap_data.size(), 16);
      chk("t1_beat0", cap_data[0], 32'h0001_0000);
      chk("t1_beat15", cap_data[15], 32'h001F_001E);
      chk("t1_last15", cap_last[15], 1'b1);
      chk("t1_comp", cap_comp[0], 1'b1);

      // one wide word forces raw mode
      w[7] = 32'h0001_0000;
      expect_block(w);
      write_block(w, 32, 1'b0, 1'b1);
      wait_drain(1'b0);
      chk("t2_count", cap_data.size(), 32);
      chk("t2_beat7", cap_data[7], 32'h0001_0000);
      chk("t2_beat31", cap_data[31], 32'h0000_001F);
      chk("t2_last31", cap_last[31], 1'b1);
      chk("t2_comp", cap_comp[0], 1'b0);

      // packed drain under backpressure
      w[7] = 32'h0000_0007;
      expect_block(w);
      write_block(w, 32, 1'b0, 1'b1);
      wait_drain(1'b1);
      chk("t3_count", cap_data.size(), 16);
      chk("t3_beat5", cap_data[5], 32'h000B_000A);

      // blk_ready alongside the 32nd write, boundary small words
      w[0]  = 32'h0000_7FFF;
      w[31] = 32'hFFFF_8000;
      expect_block(w);
      write_block(w, 32, 1'b1, 1'b1);
      wait_drain(1'b0);
      chk("t4_count", cap_data.size(), 16);
      chk("t4_beat0", cap_data[0], 32'h0001_7FFF);
      chk("t4_beat15", cap_data[15], 32'h8000_001E);
      chk("t4_comp", cap_comp[15], 1'b1);
      chk("t4_err_clean", err_o, 1'b0);

      // short block then a full raw block
      for (int i = 0; i < 32; i++) w[i] = 32'h1234_0000 + 32'(i);
      write_block(w, 20, 1'b0, 1'b0);
      chk("t5_short_err", err_o, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      w[3] = 32'h0000_8000;
      expect_block(w);
      write_block(w, 32, 1'b0, 1'b1);
      wait_drain(1'b0);
      chk("t5_count", cap_data.size(), 32);
      chk("t5_beat3", cap_data[3], 32'h0000_8000);
      chk("t5_err_sticky", err_o, 1'b1);

      // clear during beat 5 of a packed drain
      for (int i = 0; i < 32; i++) w[i] = 32'hFFFF_FF00 + 32'(i);
      expect_block(w);
      write_block(w, 32, 1'b0, 1'b1);
      cyc = 0;
      while (cap_data.size() < 5 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t6_reach_beat5", cap_data.size(), 5);
      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
      exp_q.delete();
      chk("t6_clear_valid", out_if.out_valid_o, 1'b0);
      chk("t6_clear_err", err_o, 1'b0);
      for (int i = 0; i < 32; i++) w[i] = 32'h0000_0100 + 32'(i);
      expect_block(w);
      write_block(w, 32, 1'b0, 1'b1);
      wait_drain(1'b0);
      chk("t6_new_beat0", cap_data[0], 32'h0101_0100);
      chk("t6_new_count", cap_data.size(), 16);

      // asynchronous reset in the middle of a drain
      expect_block(w);
      write_block(w, 32, 1'b0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t7_rst_valid", out_if.out_valid_o, 1'b0);
      chk("t7_rst_data", out_if.out_data_o, 32'h0);
      chk("t7_rst_beats", out_if.out_beats_o, 6'd0);
      chk("t7_rst_last", out_if.out_last_o, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t7_after_valid", out_if.out_valid_o, 1'b0);

      run = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
